vlg_rr_arbiter: RTL and testbench
=================================

// Module: vlg_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one downstream resource (bus/engine in vlg_design) among
//   REQ_NUM requesters. Grants one requester at a time, holds the grant until release, inserts
//   a one-cycle turnaround, then rotates priority so every active requester is served in turn.
// PARAMETERS
//   REQ_NUM   4    number of requesters (2..16)
//   ID_W      2    width of gnt_id; must satisfy 2**ID_W >= REQ_NUM
//   HOLD_MAX  16   max grant cycles before forced revoke (used only with ARB_TIMEOUT_EN)
//   CNT_W     5    hold counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//   clk       in   1        system clock, 100 MHz
//   rst_n     in   1        asynchronous active-low reset
//   req       in   REQ_NUM  request, one bit per requester, level-held until granted/served
//   done      in   REQ_NUM  release pulse from current owner, one bit per requester
//   gnt       out  REQ_NUM  one-hot grant (all-zero when idle), registered
//   gnt_vld   out  1        high while any gnt bit is high
//   gnt_id    out  ID_W     index of current owner; holds last owner when gnt_vld=0
//   timeout   out  1        one-cycle pulse when a grant is force-revoked
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, timeout=0, ptr=0,
//     hold_cnt=0. All outputs are registered and go to their reset values immediately on the
//     reset edge, including when reset asserts mid-grant.
//   - Priority pointer ptr: requester ptr has highest priority, then ptr+1, ... wrapping modulo
//     REQ_NUM. After each release, ptr = owner+1 (owner REQ_NUM-1 wraps to 0).
//   - FSM states IDLE, GRANT, TURN:
//     IDLE : if |req sampled at edge k, select the first set bit searching from ptr upward with
//            wrap. After edge k: gnt one-hot set, gnt_vld=1, gnt_id=owner, state=GRANT.
//            Latency from req to gnt is 1 cycle. If req=0, stay in IDLE.
//     GRANT: release when done[owner]=1, or req[owner]=0 without done. After that edge:
//            gnt=0, gnt_vld=0, ptr update, state=TURN. Otherwise hold gnt unchanged.
//     TURN : one idle turnaround cycle with gnt=0, then IDLE.
//            Minimum gnt-low gap between consecutive grants is 2 cycles.
//   - done/req bits of non-owners are ignored in GRANT. req changes in TURN are ignored.
//   - Simultaneous done[owner] and a new req[owner] in the same cycle: release proceeds.
//     The owner then has lowest priority at the next IDLE evaluation.
//   - gnt is always one-hot or zero. gnt_vld equals |gnt.
//   - hold_cnt: cleared on entry to GRANT, incremented each GRANT cycle, saturates at HOLD_MAX.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - In GRANT, when hold_cnt reaches HOLD_MAX-1 with no release, the grant is revoked
//       exactly as a release (gnt=0, ptr=owner+1, state=TURN).
//     - timeout pulses high for exactly the one cycle in which the revoke takes effect.
//     - A release on that same cycle takes precedence; no timeout pulse.
//   ARB_TIMEOUT_EN undefined:
//     - hold_cnt logic is not generated and timeout is tied to 0.
//     - The grant is held indefinitely until release.
// TESTING (clk period 10 ns, rst_n released at 1000 ns)
//   1. req=4'b0001 after reset, done[0] pulsed 3 cycles after gnt -> gnt=0001 one cycle after
//      req, held 3 cycles, gnt=0 for 2 cycles, ptr=1.
//   2. req=4'b1111 held, each owner pulses done after 1 grant cycle -> grant order 0,1,2,3,0;
//      gnt_id matches; 2-cycle gaps between grants.
//   3. ptr=2, req=4'b0011 -> requester 0 granted (wrap search); then ptr=1 -> requester 1 next.
//   4. Owner 1 drops req without done; done[3] pulsed while 1 owns -> grant released on
//      req[1] fall; done[3] has no effect.
//   5. rst_n pulsed low for 3 ns mid-GRANT with gnt=0100 -> gnt=0, gnt_vld=0, gnt_id=0
//      asynchronously; first post-reset grant follows priority from 0.
//   6. ARB_TIMEOUT_EN, HOLD_MAX=16, owner never releases -> gnt drops after 16 grant cycles,
//      timeout=1 for one cycle. Without the macro, gnt is held for 100+ cycles and timeout
//      stays 0.

Source files
------------

// File: rtl/vlg_rr_arbiter.sv
// Round-robin arbiter: one grant at a time, held until release, one turnaround cycle, then rotate.
// Optional forced revoke after HOLD_MAX grant cycles is built when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module vlg_rr_arbiter #(
    parameter int REQ_NUM  = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req,
    input  logic [REQ_NUM-1:0] done,
    output logic [REQ_NUM-1:0] gnt,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout
);

    localparam int SUM_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [REQ_NUM-1:0] gnt_reg, gnt_next;
    logic               gnt_vld_reg, gnt_vld_next;
    logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;

    logic [ID_W-1:0]    rot_idx [REQ_NUM];
    logic [REQ_NUM-1:0] req_rot;
    logic [ID_W-1:0]    sel_id;
    logic               sel_found;
    logic               owner_release;
    logic               revoke;
    logic [ID_W-1:0]    owner_inc;

    // Requests rotated so that position 0 is the current highest-priority requester.
    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rot
            logic [SUM_W-1:0] idx_sum;
            assign idx_sum     = {1'b0, ptr_reg} + SUM_W'(gi);
            assign rot_idx[gi] = (idx_sum >= SUM_W'(REQ_NUM)) ?
                                 ID_W'(idx_sum - SUM_W'(REQ_NUM)) : ID_W'(idx_sum);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_found = 1'b1;
                sel_id    = rot_idx[i];
            end
        end
    end

    // Dropping the request without done also counts as a release.
    assign owner_release = done[gnt_id_reg] | ~req[gnt_id_reg];
    assign owner_inc     = (gnt_id_reg == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id_reg + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             timeout_reg;

    assign revoke = (state_reg == GRANT) && !owner_release &&
                    (hold_cnt_reg == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_reg == IDLE && sel_found) begin
            hold_cnt_next = '0;
        end else if (state_reg == GRANT && hold_cnt_reg != CNT_W'(HOLD_MAX)) begin
            hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= revoke;
        end
    end

    assign timeout = timeout_reg;
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gnt_vld_next = gnt_vld_reg;
        gnt_id_next  = gnt_id_reg;
        ptr_next     = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    gnt_next         = '0;
                    gnt_next[sel_id] = 1'b1;
                    gnt_vld_next     = 1'b1;
                    gnt_id_next      = sel_id;
                    state_next       = GRANT;
                end
            end
            GRANT: begin
                if (owner_release || revoke) begin
                    gnt_next     = '0;
                    gnt_vld_next = 1'b0;
                    ptr_next     = owner_inc;
                    state_next   = TURN;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                gnt_next     = '0;
                gnt_vld_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gnt_vld_reg <= 1'b0;
            gnt_id_reg  <= '0;
            ptr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gnt_vld_reg <= gnt_vld_next;
            gnt_id_reg  <= gnt_id_next;
            ptr_reg     <= ptr_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_vld = gnt_vld_reg;
    assign gnt_id  = gnt_id_reg;

    a_params_ok: assert property (@(posedge clk)
        (2 ** CNT_W > HOLD_MAX) && (2 ** ID_W >= REQ_NUM) && (REQ_NUM >= 2));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_reg));
    a_vld_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_vld_reg == (|gnt_reg));

endmodule

// File: tb/tb_vlg_rr_arbiter.sv
// Directed bench for vlg_rr_arbiter: rotation order, wrap search, release rules, async reset, hold limit.
`timescale 1ns/1ps

module tb_vlg_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int held;
    int to_seen;
    int exp_id;

    vlg_rr_arbiter #(
        .REQ_NUM (4),
        .ID_W    (2),
        .HOLD_MAX(16),
        .CNT_W   (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_vld(gnt_vld),
        .gnt_id (gnt_id),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, obs, exp);
        end else begin
            $display("[%0t] ok   %s = %0h", $time, tag, obs);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_gid);
        check_val({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, ".vld"}, 32'(gnt_vld), 32'(|exp_gnt));
        check_val({tag, ".id"}, 32'(gnt_id), 32'(exp_gid));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        #500;
        chk_grant("reset", 4'b0000, 2'd0);
        check_val("reset.timeout", 32'(timeout), 32'd0);
        #500;
        rst_n = 1'b1;
        tick;

        // single requester, released by done after three grant cycles
        req = 4'b0001;
        tick; chk_grant("t1_c1", 4'b0001, 2'd0);
        tick; chk_grant("t1_c2", 4'b0001, 2'd0);
        tick; chk_grant("t1_c3", 4'b0001, 2'd0);
        done = 4'b0001;
        tick; done = 4'b0000; req = 4'b0000;
        chk_grant("t1_gap1", 4'b0000, 2'd0);
        tick; chk_grant("t1_gap2", 4'b0000, 2'd0);

        // ptr is now 1: requester 1 wins over 0
        req = 4'b0011;
        tick; chk_grant("t1_ptr1", 4'b0010, 2'd1);
        done = 4'b0010;
        tick; done = 4'b0000;
        chk_grant("t3_rel1", 4'b0000, 2'd1);
        tick; chk_grant("t3_gap", 4'b0000, 2'd1);
        // ptr is 2, only 0 and 1 request: wrap search picks 0
        tick; chk_grant("t3_wrap", 4'b0001, 2'd0);
        done = 4'b0001;
        tick; done = 4'b0000;
        chk_grant("t3_rel0", 4'b0000, 2'd0);
        tick;
        tick; chk_grant("t3_next", 4'b0010, 2'd1);

        // non-owner done ignored; owner releases by dropping req
        done = 4'b1000;
        tick; done = 4'b0000;
        chk_grant("t4_done3", 4'b0010, 2'd1);
        req = 4'b1001;
        tick; chk_grant("t4_drop", 4'b0000, 2'd1);
        tick;
        tick; chk_grant("t4_next", 4'b1000, 2'd3);
        done = 4'b1000; req = 4'b0000;
        tick; done = 4'b0000;
        chk_grant("t4_rel3", 4'b0000, 2'd3);
        tick;

        // all requesting: 0,1,2,3,0 with two-cycle gaps
        req = 4'b1111;
        tick;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            chk_grant($sformatf("t2_g%0d", k), 4'(1 << exp_id), 2'(exp_id));
            done = 4'(1 << exp_id);
            if (k == 4) req = 4'b0000;
            tick; done = 4'b0000;
            chk_grant($sformatf("t2_gap1_%0d", k), 4'b0000, 2'(exp_id));
            tick;
            chk_grant($sformatf("t2_gap2_%0d", k), 4'b0000, 2'(exp_id));
            if (k < 4) tick;
        end

        // async reset mid-grant, then priority restarts at 0
        req = 4'b0100;
        tick; chk_grant("t5_gnt", 4'b0100, 2'd2);
        #3; rst_n = 1'b0;
        #1; chk_grant("t5_rst", 4'b0000, 2'd0);
        check_val("t5_rst.timeout", 32'(timeout), 32'd0);
        #2; rst_n = 1'b1; req = 4'b1001;
        tick; chk_grant("t5_post", 4'b0001, 2'd0);
        done = 4'b0001; req = 4'b0000;
        tick; done = 4'b0000;
        chk_grant("t5_rel", 4'b0000, 2'd0);
        tick;

        // owner never releases
        req = 4'b0010;
        tick;
        held    = 0;
        to_seen = 0;
        for (int i = 0; i < 110; i++) begin
            if (gnt !== 4'b0010) break;
            if (timeout !== 1'b0) to_seen = 1;
            held++;
            tick;
        end
`ifdef ARB_TIMEOUT_EN
        check_val("t6_held", 32'(held), 32'd16);
        check_val("t6_early_to", 32'(to_seen), 32'd0);
        check_val("t6_to_pulse", 32'(timeout), 32'd1);
        chk_grant("t6_revoked", 4'b0000, 2'd1);
        req = 4'b0000;
        tick;
        check_val("t6_to_end", 32'(timeout), 32'd0);
`else
        check_val("t6_held", 32'(held), 32'd110);
        check_val("t6_to", 32'(to_seen), 32'd0);
        chk_grant("t6_still", 4'b0010, 2'd1);
        done = 4'b0010; req = 4'b0000;
        tick; done = 4'b0000;
        chk_grant("t6_rel", 4'b0000, 2'd1);
        check_val("t6_to_end", 32'(timeout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
